// File: rtl/hov_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hov_pkg : shared constants for the Hovalaag host loader                   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package hov_pkg;

  localparam int AW_DEFAULT  = 8;
  localparam int PDW_DEFAULT = 32;
  localparam int IDW_DEFAULT = 12;

  localparam logic [1:0] ST_HALT   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_PROG = 2'd1;
  localparam logic [1:0] SEL_IN1  = 2'd2;
  localparam logic [1:0] SEL_IN2  = 2'd3;

  // Program commits outrank input-1, which outranks input-2.
  function automatic logic [1:0] select_winner(input logic p, input logic i1, input logic i2);
    if (p)  return SEL_PROG;
    if (i1) return SEL_IN1;
    if (i2) return SEL_IN2;
    return SEL_NONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hov_sp_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hov_sp_ram : one write port, one registered read port, old data on RDW    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hov_sp_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Both processes use non-blocking updates, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/hov_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hov_loader : host commits -> program/input RAMs, CPU hold sequencing      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module hov_loader
  import hov_pkg::*;
#(
  parameter int AW            = AW_DEFAULT,
  parameter int PDW           = PDW_DEFAULT,
  parameter int IDW           = IDW_DEFAULT,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           program_set,
  input  logic [AW-1:0]  program_addr,
  input  logic [PDW-1:0] program_data,
  input  logic           input1_set,
  input  logic           input2_set,
  input  logic [AW-1:0]  input_addr,
  input  logic [IDW-1:0] input_data,
  input  logic [AW-1:0]  cpu_pc,
  output logic [PDW-1:0] cpu_instr,
  input  logic [AW-1:0]  cpu_in1_addr,
  output logic [IDW-1:0] cpu_in1_data,
  input  logic [AW-1:0]  cpu_in2_addr,
  output logic [IDW-1:0] cpu_in2_data,
  output logic           cpu_hold,
  output logic [AW:0]    load_count,
  output logic           collision
);

  localparam int          CW        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [AW:0] COUNT_MAX = {1'b1, {AW{1'b0}}};

  logic           prog_set_q, in1_set_q, in2_set_q;
  logic [AW-1:0]  prog_addr_q, in_addr_q;
  logic [PDW-1:0] prog_data_q;
  logic [IDW-1:0] in_data_q;

  logic [1:0]     state;
  logic [CW-1:0]  settle_cnt;
  logic [1:0]     prev_win;
  logic [AW-1:0]  prev_addr;

  logic [1:0]     win;
  logic           any_set;
  logic [AW-1:0]  win_addr;
  logic           new_word;
  logic           multi_set;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prog_set_q  <= 1'b0;
      in1_set_q   <= 1'b0;
      in2_set_q   <= 1'b0;
      prog_addr_q <= '0;
      in_addr_q   <= '0;
      prog_data_q <= '0;
      in_data_q   <= '0;
    end else begin
      prog_set_q  <= program_set;
      in1_set_q   <= input1_set;
      in2_set_q   <= input2_set;
      prog_addr_q <= program_addr;
      in_addr_q   <= input_addr;
      prog_data_q <= program_data;
      in_data_q   <= input_data;
    end
  end

  always_comb begin
    win       = select_winner(prog_set_q, in1_set_q, in2_set_q);
    any_set   = (win != SEL_NONE);
    win_addr  = (win == SEL_PROG) ? prog_addr_q : in_addr_q;
    new_word  = any_set && ((win != prev_win) || (win_addr != prev_addr));
    multi_set = (prog_set_q & in1_set_q) | (prog_set_q & in2_set_q) | (in1_set_q & in2_set_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_HALT;
      settle_cnt <= '0;
      load_count <= '0;
      collision  <= 1'b0;
      prev_win   <= SEL_NONE;
      prev_addr  <= '0;
    end else begin
      prev_win  <= win;
      prev_addr <= win_addr;
      if (multi_set) collision <= 1'b1;
      if (new_word && (load_count != COUNT_MAX)) load_count <= load_count + 1'b1;

      case (state)
        ST_HALT, ST_RUN: begin
          // A fresh load session restarts the count, including this first word.
          if (any_set) begin
            state      <= ST_LOAD;
            load_count <= {{AW{1'b0}}, new_word};
          end
        end
        ST_LOAD: begin
          if (!any_set) begin
            state      <= ST_SETTLE;
            settle_cnt <= CW'(SETTLE_CYCLES - 1);
          end
        end
        ST_SETTLE: begin
          if (any_set)                state      <= ST_LOAD;
          else if (settle_cnt == '0)  state      <= ST_RUN;
          else                        settle_cnt <= settle_cnt - 1'b1;
        end
        default: state <= ST_HALT;
      endcase
    end
  end

  assign cpu_hold = (state != ST_RUN);

  // Writes are suppressed while reset is asserted so an aborted load leaves no stray word.
  hov_sp_ram #(.AW(AW), .DW(PDW)) u_prog_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rst_n && (win == SEL_PROG)),
    .waddr (prog_addr_q),
    .wdata (prog_data_q),
    .raddr (cpu_pc),
    .rdata (cpu_instr)
  );

  hov_sp_ram #(.AW(AW), .DW(IDW)) u_in1_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rst_n && (win == SEL_IN1)),
    .waddr (in_addr_q),
    .wdata (in_data_q),
    .raddr (cpu_in1_addr),
    .rdata (cpu_in1_data)
  );

  hov_sp_ram #(.AW(AW), .DW(IDW)) u_in2_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rst_n && (win == SEL_IN2)),
    .waddr (in_addr_q),
    .wdata (in_data_q),
    .raddr (cpu_in2_addr),
    .rdata (cpu_in2_data)
  );

endmodule
`default_nettype wire
